// File: rtl/bubble_pkg.sv
// Shared types and constants for the bubble-sort display engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bubble_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPARE,
        SWAP,
        DONE
    } state_t;

    // Galois feedback taps for the 16-bit maximal-length LFSR
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    // Spacing between default/preset bar heights
    localparam int          HEIGHT_STEP = 10;
    // Width of the bar index / pass / load counters
    localparam int          IDX_W       = 3;

    // One right-shift Galois step
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bubble_sort_engine_if.sv
// Command/status bundle between the sort engine and its controller/display.
// Latency: n/a (wires only).
// Backpressure: none; commands are single-cycle pulses.
interface bubble_sort_engine_if #(
    parameter int N_BARS = 5,
    parameter int H_W    = 7
);
    logic                    load;
    logic                    preset;
    logic                    start;
    logic [N_BARS*H_W-1:0]   heights_flat;
    logic [2:0]              cmp_idx;
    logic                    swap_flag;
    logic                    busy;
    logic                    done;

    modport master (
        output load, preset, start,
        input  heights_flat, cmp_idx, swap_flag, busy, done
    );

    modport slave (
        input  load, preset, start,
        output heights_flat, cmp_idx, swap_flag, busy, done
    );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the random height source.
// Latency: advances every clk; q is the register value.
// Backpressure: none.
module lfsr16
    import bubble_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] lfsr_q;

    // Reload seed in reset, otherwise step once per clock
    always_ff @(posedge clk) begin
        if (!reset) lfsr_q <= seed;
        else        lfsr_q <= lfsr_step(lfsr_q);
    end

    assign q = lfsr_q;
endmodule

// File: rtl/bubble_sort_engine.sv
// Step-by-step ascending bubble sort of N_BARS heights for the bar-graph display.
// Latency: one compare or swap per step tick (STEP_DIV clocks); LOAD takes N_BARS clocks.
// Backpressure: none; load > preset > start, start ignored while busy. Macro BUBBLE_EARLY_EXIT_EN.
module bubble_sort_engine
    import bubble_pkg::*;
#(
    parameter int          N_BARS   = 5,
    parameter int          H_W      = 7,
    parameter int          STEP_DIV = 25_000_000,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    bubble_sort_engine_if.slave   bus
);
    localparam int            PW         = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

    state_t             state_q, state_d;
    logic [H_W-1:0]     h_q [N_BARS];
    logic [H_W-1:0]     h_d [N_BARS];
    logic [IDX_W-1:0]   j_q, j_d, pass_q, pass_d, k_q, k_d;
    logic               swapped_q, swapped_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic               swap_flag_q, swap_flag_d, busy_q, busy_d, done_q, done_d;
    logic               tick, do_adv, early_exit;
    logic [15:0]        lfsr_val;
    logic               unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr_val)
    );

    // Only the low six LFSR bits feed heights
    assign unused_lfsr_hi = ^lfsr_val[15:6];
    assign tick           = (presc_q == PRESC_LAST);

    // Next-state: commands first (by priority), then tick-driven sort steps
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        j_d        = j_q;
        pass_d     = pass_q;
        k_d        = k_q;
        swapped_d  = swapped_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        do_adv     = 1'b0;
        early_exit = 1'b0;
        if (bus.load) begin
            state_d   = LOAD;
            k_d       = '0;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
        end else if (bus.preset) begin
            for (int i = 0; i < N_BARS; i++) h_d[i] = H_W'((N_BARS - i) * HEIGHT_STEP);
            state_d   = IDLE;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
        end else if (bus.start && (state_q == IDLE || state_q == DONE)) begin
            state_d   = COMPARE;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
            presc_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    // A zero-height bar would vanish on the display
                    h_d[k_q] = (lfsr_val[5:0] == 6'd0) ? H_W'(1) : H_W'(lfsr_val[5:0]);
                    if (k_q == IDX_W'(N_BARS - 1)) state_d = IDLE;
                    else                           k_d     = k_q + 1'b1;
                end
                COMPARE: if (tick) begin
                    // Strict compare keeps equal heights in place
                    if (h_q[j_q] > h_q[j_q + 1'b1]) state_d = SWAP;
                    else                            do_adv  = 1'b1;
                end
                SWAP: if (tick) begin
                    h_d[j_q]        = h_q[j_q + 1'b1];
                    h_d[j_q + 1'b1] = h_q[j_q];
                    swapped_d       = 1'b1;
                    do_adv          = 1'b1;
                end
                default: ;
            endcase
`ifdef BUBBLE_EARLY_EXIT_EN
            early_exit = !swapped_d;
`endif
            if (do_adv) begin
                if (int'(j_q) + 1 < N_BARS - 1 - int'(pass_q)) begin
                    j_d     = j_q + 1'b1;
                    state_d = COMPARE;
                end else begin
                    pass_d    = pass_q + 1'b1;
                    j_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = (int'(pass_q) + 1 == N_BARS - 1 || early_exit) ? DONE : COMPARE;
                end
            end
        end
        cmp_idx_d   = (state_d == COMPARE || state_d == SWAP) ? j_d : '0;
        swap_flag_d = (state_d == SWAP);
        busy_d      = (state_d == COMPARE || state_d == SWAP || state_d == LOAD);
        done_d      = (state_d == DONE);
    end

    // State, heights, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < N_BARS; i++) h_q[i] <= H_W'((i + 1) * HEIGHT_STEP);
            j_q         <= '0;
            pass_q      <= '0;
            k_q         <= '0;
            swapped_q   <= 1'b0;
            presc_q     <= '0;
            cmp_idx_q   <= '0;
            swap_flag_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            j_q         <= j_d;
            pass_q      <= pass_d;
            k_q         <= k_d;
            swapped_q   <= swapped_d;
            presc_q     <= presc_d;
            cmp_idx_q   <= cmp_idx_d;
            swap_flag_q <= swap_flag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Pack bar heights for the display, bar i in slice i
    always_comb begin
        bus.heights_flat = '0;
        for (int i = 0; i < N_BARS; i++) bus.heights_flat[i*H_W +: H_W] = h_q[i];
    end

    assign bus.cmp_idx   = cmp_idx_q;
    assign bus.swap_flag = swap_flag_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine with STEP_DIV=1, N_BARS=5.
// Expected outputs come from a plain nested-loop bubble sort trace and an LFSR model.
// Randomized load timing and start-while-busy positions.
module tb_bubble_sort_engine;
    localparam int          N    = 5;
    localparam int          HW   = 7;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef BUBBLE_EARLY_EXIT_EN
    localparam int SORTED_LEN = 5;
`else
    localparam int SORTED_LEN = 11;
`endif

    typedef struct packed {
        logic [N*HW-1:0] h;
        logic [2:0]      cmp;
        logic            swp;
        logic            bsy;
        logic            dn;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bubble_sort_engine_if #(.N_BARS(N), .H_W(HW)) bus ();

    bubble_sort_engine #(.N_BARS(N), .H_W(HW), .STEP_DIV(1), .SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          vectors   = 0;
    int          errors    = 0;
    int          cyc_no    = 0;
    int          dut_swaps = 0;
    obs_t        expq[$];
    obs_t        trace[$];
    int          tswaps;
    int          mh[N];
    bit          mdone;
    logic [15:0] ml;
    obs_t        e_c, a_c;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int map_h(input logic [15:0] s);
        return (s[5:0] == 6'd0) ? 1 : int'(s[5:0]);
    endfunction

    function automatic obs_t snap(input int h[N], input int cmp, input bit swp, input bit bsy, input bit dn);
        obs_t o;
        o.h = '0;
        for (int i = 0; i < N; i++) o.h[i*HW +: HW] = HW'(h[i]);
        o.cmp = 3'(cmp);
        o.swp = swp;
        o.bsy = bsy;
        o.dn  = dn;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Compare process: one registered-output snapshot per cycle, 1 time unit after posedge
    always begin
        @(posedge clk);
        #1;
        if (bus.swap_flag === 1'b1) dut_swaps++;
        if (expq.size() != 0) begin
            e_c = expq.pop_front();
            a_c = {bus.heights_flat, bus.cmp_idx, bus.swap_flag, bus.busy, bus.done};
            cyc_no++;
            vectors++;
            if (a_c !== e_c) begin
                errors++;
                $display("FAIL outputs cycle %0d: got h=%h cmp=%0d swp=%b busy=%b done=%b, expected h=%h cmp=%0d swp=%b busy=%b done=%b",
                         cyc_no, a_c.h, a_c.cmp, a_c.swp, a_c.bsy, a_c.dn, e_c.h, e_c.cmp, e_c.swp, e_c.bsy, e_c.dn);
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be after that edge
    task automatic cyc(input bit ld, input bit pr, input bit st, input bit rn, input obs_t e);
        @(negedge clk);
        bus.load   = ld;
        bus.preset = pr;
        bus.start  = st;
        reset      = rn;
        expq.push_back(e);
        ml = rn ? lfsr_next(ml) : SEED;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, snap(mh, 0, 0, 0, mdone));
    endtask

    task automatic set_mh(input obs_t t);
        for (int i = 0; i < N; i++) mh[i] = int'(t.h[i*HW +: HW]);
    endtask

    // Reference: textbook bubble sort, one entry per displayed step
    task automatic build_trace();
        int h[N];
        bit sw;
        int t;
        h = mh;
        trace.delete();
        tswaps = 0;
        for (int p = 0; p < N - 1; p++) begin
            sw = 0;
            for (int j = 0; j < N - 1 - p; j++) begin
                trace.push_back(snap(h, j, 0, 1, 0));
                if (h[j] > h[j+1]) begin
                    trace.push_back(snap(h, j, 1, 1, 0));
                    t = h[j]; h[j] = h[j+1]; h[j+1] = t;
                    sw = 1;
                    tswaps++;
                end
            end
`ifdef BUBBLE_EARLY_EXIT_EN
            if (!sw) break;
`endif
        end
        trace.push_back(snap(h, 0, 0, 0, 1));
    endtask

    task automatic run_sort(input int busy_start_idx);
        dut_swaps = 0;
        cyc(0, 0, 1, 1, trace[0]);
        for (int i = 1; i < trace.size(); i++) cyc(0, 0, (i == busy_start_idx), 1, trace[i]);
        set_mh(trace[trace.size()-1]);
        mdone = 1;
        idle(1);
        check("swap_count", dut_swaps, tswaps);
    endtask

    task automatic do_preset();
        for (int i = 0; i < N; i++) mh[i] = (N - i) * 10;
        mdone = 0;
        cyc(0, 1, 0, 1, snap(mh, 0, 0, 0, 0));
    endtask

    task automatic do_load();
        mdone = 0;
        cyc(1, 0, 0, 1, snap(mh, 0, 0, 1, 0));
        for (int k = 0; k < N; k++) begin
            mh[k] = map_h(ml);
            cyc(0, 0, 0, 1, snap(mh, 0, 0, (k < N - 1), 0));
        end
    endtask

    // Choose an idle delay so the next load yields an x,x,smaller pattern
    task automatic find_delay(output int d, output bit ok);
        logic [15:0] s, t;
        int v[N];
        s  = ml;
        ok = 0;
        d  = 0;
        for (int dd = 0; dd < 3000 && !ok; dd++) begin
            t = lfsr_next(s);
            for (int k = 0; k < N; k++) begin
                v[k] = map_h(t);
                t = lfsr_next(t);
            end
            for (int i = 0; i < N - 2; i++)
                if (v[i] == v[i+1] && v[i+2] < v[i]) ok = 1;
            if (ok) d = dd;
            s = lfsr_next(s);
        end
    endtask

    task automatic check_dut_sorted(input int inp[N]);
        int          sq[$];
        logic [N*HW-1:0] hf;
        for (int i = 0; i < N; i++) sq.push_back(inp[i]);
        sq.sort();
        hf = bus.heights_flat;
        for (int i = 0; i < N; i++) check($sformatf("sorted_perm[%0d]", i), hf[i*HW +: HW], sq[i]);
    endtask

    initial begin
        int inp[N];
        int d;
        bit ok;
        logic [N*HW-1:0] hf;
        bus.load   = 0;
        bus.preset = 0;
        bus.start  = 0;

        // Pin the reference models with hand-computed values
        check("lfsr_pin0", lfsr_next(16'hACE1), 16'hE270);
        check("lfsr_pin1", lfsr_next(16'hE270), 16'h7138);

        // Reset state
        mh    = '{10, 20, 30, 40, 50};
        mdone = 0;
        cyc(0, 0, 0, 0, snap(mh, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, snap(mh, 0, 0, 0, 0));
        idle(2);

        // Already sorted input: no swaps, done after 10 (or 4) ticks
        build_trace();
        check("trace_len_sorted", trace.size(), SORTED_LEN);
        check("trace_swaps_sorted", tswaps, 0);
        run_sort(-1);
        idle(3);
        // Restart from DONE
        build_trace();
        run_sort(-1);

        // Descending preset: 10 compares + 10 swaps, start while busy ignored
        do_preset();
        idle(1);
        build_trace();
        check("trace_len_desc", trace.size(), 21);
        check("trace_swaps_desc", tswaps, 10);
        run_sort(5);
        hf = bus.heights_flat;
        for (int i = 0; i < N; i++) check($sformatf("desc_final[%0d]", i), hf[i*HW +: HW], (i + 1) * 10);
        check("desc_done", bus.done, 1);
        check("desc_busy", bus.busy, 0);
        idle(2);

        // Load at tick 7 aborts the sort; done never rises
        do_preset();
        build_trace();
        cyc(0, 0, 1, 1, trace[0]);
        for (int i = 1; i < 7; i++) cyc(0, 0, 0, 1, trace[i]);
        set_mh(trace[6]);
        do_load();
        idle(4);

        // Random loads at random times, then sort
        for (int r = 0; r < 4; r++) begin
            idle($urandom_range(0, 20));
            do_load();
            idle(1);
            hf = bus.heights_flat;
            for (int i = 0; i < N; i++) check($sformatf("load_nonzero[%0d]", i), (hf[i*HW +: HW] != 0), 1);
            inp = mh;
            build_trace();
            run_sort($urandom_range(1, trace.size() - 1));
            check_dut_sorted(inp);
        end

        // Equal neighbours ahead of a smaller bar: equal pair never swaps
        find_delay(d, ok);
        check("equal_pattern_found", ok, 1);
        idle(d);
        do_load();
        inp = mh;
        build_trace();
        run_sort(-1);
        check_dut_sorted(inp);

        // Reset mid-sort returns to defaults immediately
        do_preset();
        build_trace();
        cyc(0, 0, 1, 1, trace[0]);
        for (int i = 1; i < 5; i++) cyc(0, 0, 0, 1, trace[i]);
        mh    = '{10, 20, 30, 40, 50};
        mdone = 0;
        cyc(0, 0, 0, 0, snap(mh, 0, 0, 0, 0));
        idle(3);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
